imm_decode_ctrl: RTL
====================

// Module: imm_decode_ctrl
// PURPOSE
//   Decode-stage controller for the immediate extender in the pipelined RV32I core.
//   - Classifies the incoming instruction opcode.
//   - Drives the extender's 2-bit select and captures its 32-bit result.
//   - Registers instr/pc/imm into the ID/EX slot under a valid/ready handshake, with stall and flush.
//   - Traps on illegal opcodes and counts accepted instructions.
// PARAMETERS
//   CNT_W    16  width of accepted-instruction counter (wraps modulo 2^CNT_W)
//   TRAP_EN  1   1: illegal opcode enters TRAP state; 0: forwarded with ex_illegal=1, imm_sel=00
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   id_valid     in   1      id_instr/id_pc valid
//   id_ready     out  1      controller accepts id_instr this cycle
//   id_instr     in   32     fetched instruction
//   id_pc        in   32     pc of id_instr
//   imm_sel      out  2      extender select (combinational from id_instr[6:0])
//   imm_in       in   32     extender result for id_instr under imm_sel (combinational return)
//   ex_valid     out  1      ID/EX slot holds an instruction
//   ex_ready     in   1      EX consumes slot this cycle (0 = downstream stall)
//   ex_instr     out  32     registered instruction
//   ex_pc        out  32     registered pc
//   ex_imm       out  32     registered immediate
//   ex_imm_used  out  1      0 for R-type (ex_imm is don't-care)
//   ex_illegal   out  1      illegal opcode forwarded (TRAP_EN=0 only)
//   flush        in   1      kill ID/EX slot and pending trap (branch/jump redirect)
//   trap         out  1      high while in TRAP state
//   trap_pc      out  32     pc of trapping instruction
//   trap_ack     in   1      releases TRAP
//   instr_count  out  CNT_W  legal instructions accepted since reset
// BEHAVIOUR
//   Reset: state=RUN.
//     - All registered outputs reset to 0: ex_valid, ex_instr, ex_pc, ex_imm, ex_imm_used, ex_illegal, trap, trap_pc, instr_count.
//   imm_sel from opcode id_instr[6:0]; decoded whenever id_valid=1 or not:
//     0000011 load          -> 00, used=1
//     0010011 op-imm        -> 01, used=1
//     1100111 jalr          -> 01, used=1
//     0100011 store         -> 10, used=1
//     1100011 branch        -> 10, used=1
//     0110111 lui           -> 11, used=1
//     0010111 auipc         -> 11, used=1
//     1101111 jal           -> 11, used=1
//     0110011 R-type        -> 00, used=0
//     any other opcode      -> 00, illegal
//   id_ready = (state==RUN) & ~flush & (~ex_valid | ex_ready). Combinational; no dependency on id_valid.
//   accept = id_valid & id_ready. Latency 1: on accept, next edge loads ex_* from id_instr/id_pc/imm_in.
//   Slot update per edge, in priority order:
//     1. flush -> ex_valid<=0, state<=RUN, trap<=0.
//     2. accept of a legal opcode -> ex_valid<=1, ex_* loaded, instr_count+1.
//     3. ex_ready & ex_valid -> ex_valid<=0.
//     4. otherwise hold all ex_* values (stall).
//   Illegal opcode on accept, TRAP_EN=1:
//     - Not loaded into the slot; ex_valid follows rule 3/4.
//     - Next edge: state<=TRAP, trap<=1, trap_pc<=id_pc.
//     - instr_count unchanged.
//   Illegal opcode on accept, TRAP_EN=0:
//     - Loaded like a legal instruction, with ex_illegal=1 and ex_imm_used=0.
//     - Counted in instr_count.
//   TRAP state:
//     - id_ready=0; the slot still drains via ex_ready.
//     - trap_ack -> next edge RUN, trap<=0; trap_pc holds its value.
//     - trap_ack while in RUN is ignored.
//   Simultaneous events:
//     - flush and trap_ack together -> RUN (flush wins, same result).
//     - ex_ready and accept in the same cycle -> slot replaced, ex_valid stays 1.
//   instr_count wraps from 2^CNT_W-1 to 0; no saturation.
//   Reset mid-operation: immediate return to reset values; any in-flight slot or trap is discarded.
// TESTING
//   1. addi x1,x0,-1 (0xFFF00093), pc=0x100, ex_ready=1
//      -> imm_sel=01 same cycle; next cycle ex_valid=1, ex_imm=0xFFFFFFFF, ex_pc=0x100, instr_count=1.
//   2. Back-to-back sw, beq, lui, jal with ex_ready=1
//      -> imm_sel 10,10,11,11; one slot load per cycle; id_ready held 1; instr_count=4.
//   3. ex_ready=0 for 3 cycles with slot full
//      -> id_ready=0, ex_* stable.
//      -> ex_ready=1 with id_valid=1: slot replaced in one cycle, ex_valid stays 1.
//   4. Opcode 0x7F at pc=0x200, TRAP_EN=1
//      -> trap=1, trap_pc=0x200, id_ready=0, instr_count unchanged.
//      -> trap_ack pulse: RUN next cycle.
//      -> Repeat with TRAP_EN=0: ex_illegal=1, no trap.
//   5. flush with slot full and a concurrent accept
//      -> next cycle ex_valid=0, no load, instr_count unchanged.
//      -> flush during TRAP clears trap.
//   6. CNT_W=4, 17 legal accepts -> instr_count=1.
//      -> Assert rst mid-stall: all outputs 0 asynchronously.

Source files
------------

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage controller for the RV32I immediate extender.
// Classifies the opcode, drives the extender select, and captures the
// instruction, pc and immediate into the ID/EX slot under a valid/ready
// handshake with flush, illegal-opcode trap and an accepted-instruction count.
module imm_decode_ctrl #(
    parameter int CNT_W   = 16,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_pc,
    output logic [1:0]       imm_sel,
    input  logic [31:0]      imm_in,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [31:0]      ex_instr,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_imm,
    output logic             ex_imm_used,
    output logic             ex_illegal,
    input  logic             flush,
    output logic             trap,
    output logic [31:0]      trap_pc,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t     state_r;
    logic [3:0] dec_s;
    logic [1:0] sel_s;
    logic       used_s;
    logic       illegal_s;
    logic       accept_s;
    logic       load_s;
    logic       trap_take_s;

    // Opcode classification, packed as {illegal, imm_used, sel[1:0]}.
    function automatic logic [3:0] decode_op(input logic [6:0] op);
        case (op)
            7'b0000011: decode_op = 4'b0100; // load
            7'b0010011: decode_op = 4'b0101; // op-imm
            7'b1100111: decode_op = 4'b0101; // jalr
            7'b0100011: decode_op = 4'b0110; // store
            7'b1100011: decode_op = 4'b0110; // branch
            7'b0110111: decode_op = 4'b0111; // lui
            7'b0010111: decode_op = 4'b0111; // auipc
            7'b1101111: decode_op = 4'b0111; // jal
            7'b0110011: decode_op = 4'b0000; // R-type, no immediate
            default:    decode_op = 4'b1000; // illegal
        endcase
    endfunction

    // Decode the opcode regardless of id_valid so the extender result is ready early.
    always_comb begin
        dec_s     = decode_op(id_instr[6:0]);
        illegal_s = dec_s[3];
        used_s    = dec_s[2];
        sel_s     = dec_s[1:0];
    end

    assign imm_sel = sel_s;

    // Handshake: accept only in RUN, not during flush, and when the slot can take a new entry.
    always_comb begin
        id_ready    = (state_r == ST_RUN) & ~flush & (~ex_valid | ex_ready);
        accept_s    = id_valid & id_ready;
        load_s      = accept_s & (~illegal_s | ~TRAP_EN);
        trap_take_s = accept_s & illegal_s & TRAP_EN;
    end

    // ID/EX slot, trap state and instruction counter; flush has top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            ex_valid    <= 1'b0;
            ex_instr    <= 32'h0000_0000;
            ex_pc       <= 32'h0000_0000;
            ex_imm      <= 32'h0000_0000;
            ex_imm_used <= 1'b0;
            ex_illegal  <= 1'b0;
            trap        <= 1'b0;
            trap_pc     <= 32'h0000_0000;
            instr_count <= {CNT_W{1'b0}};
        end else if (flush) begin
            ex_valid <= 1'b0;
            state_r  <= ST_RUN;
            trap     <= 1'b0;
        end else begin
            if (load_s) begin
                ex_valid    <= 1'b1;
                ex_instr    <= id_instr;
                ex_pc       <= id_pc;
                ex_imm      <= imm_in;
                ex_imm_used <= used_s & ~illegal_s;
                ex_illegal  <= illegal_s;
                instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (ex_ready && ex_valid) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid <= ex_valid;
            end

            if (trap_take_s) begin
                state_r <= ST_TRAP;
                trap    <= 1'b1;
                trap_pc <= id_pc;
            end else if ((state_r == ST_TRAP) && trap_ack) begin
                state_r <= ST_RUN;
                trap    <= 1'b0;
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule
